// File: rtl/perf_hex_axil_writer.sv
// Retired-instruction rate meter: counts pulses over a fixed window and posts each
// window's saturated count to the 7-segment display register as one AXI-lite write.
module perf_hex_axil_writer #(
   parameter int                    DATA_WIDTH    = 32,
   parameter int                    ADDR_WIDTH    = 16,
   parameter int                    STRB_WIDTH    = DATA_WIDTH / 8,
   parameter logic [ADDR_WIDTH-1:0] HEX_ADDR      = 16'h0000,
   parameter int                    UPDATE_PERIOD = 50000000,
   parameter int                    COUNT_SHIFT   = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  enable,
   input  logic                  instr_retired,
   output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
   output logic [2:0]            m_axil_awprot,
   output logic                  m_axil_awvalid,
   input  logic                  m_axil_awready,
   output logic [DATA_WIDTH-1:0] m_axil_wdata,
   output logic [STRB_WIDTH-1:0] m_axil_wstrb,
   output logic                  m_axil_wvalid,
   input  logic                  m_axil_wready,
   input  logic [1:0]            m_axil_bresp,
   input  logic                  m_axil_bvalid,
   output logic                  m_axil_bready,
   output logic                  busy,
   output logic [7:0]            overrun_cnt,
   output logic                  resp_err
);

   localparam int PCW = (UPDATE_PERIOD > 1) ? $clog2(UPDATE_PERIOD) : 1;

   typedef enum logic [1:0] {
      IDLE,
      ADDR_DATA,
      RESP
   } state_t;

   state_t                  state, state_next;
   logic [PCW-1:0]          period_cnt;
   logic [31:0]             window_cnt;
   logic [31:0]             window_total;
   logic [31:0]             shifted;
   logic [15:0]             snap16;
   logic [31:0]             snap_word;
   logic                    tc;
   logic                    pending;
   logic [31:0]             pending_word;
   logic                    awvalid_q, wvalid_q;
   logic                    awvalid_next, wvalid_next;
   logic                    launch;
   logic [DATA_WIDTH-1:0]   wdata_q;

   assign tc = enable && (period_cnt == PCW'(UPDATE_PERIOD - 1));

   // A pulse arriving in the terminal cycle still belongs to the ending window.
   assign window_total = (instr_retired && (window_cnt != '1)) ? window_cnt + 32'd1 : window_cnt;
   assign shifted      = window_total >> COUNT_SHIFT;
   assign snap16       = (shifted > 32'h0000_FFFF) ? 16'hFFFF : shifted[15:0];
   assign snap_word    = {snap16[15:8], 16'h0000, snap16[7:0]};

   assign m_axil_awaddr  = HEX_ADDR;
   assign m_axil_awprot  = 3'b000;
   assign m_axil_awvalid = awvalid_q;
   assign m_axil_wdata   = wdata_q;
   assign m_axil_wstrb   = '1;
   assign m_axil_wvalid  = wvalid_q;
   assign m_axil_bready  = (state == RESP);
   assign busy           = (state != IDLE);

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      state_next   = state;
      awvalid_next = awvalid_q;
      wvalid_next  = wvalid_q;
      launch       = 1'b0;
      unique case (state)
         IDLE: begin
            if (pending) begin
               launch       = 1'b1;
               awvalid_next = 1'b1;
               wvalid_next  = 1'b1;
               state_next   = ADDR_DATA;
            end
         end
         ADDR_DATA: begin
            // Each valid retires on its own handshake; both gone means both channels accepted.
            if (m_axil_awready) awvalid_next = 1'b0;
            if (m_axil_wready)  wvalid_next  = 1'b0;
            if (!awvalid_next && !wvalid_next) state_next = RESP;
         end
         RESP: begin
            if (m_axil_bvalid) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         awvalid_q <= 1'b0;
         wvalid_q  <= 1'b0;
         wdata_q   <= '0;
         resp_err  <= 1'b0;
      end else begin
         state     <= state_next;
         awvalid_q <= awvalid_next;
         wvalid_q  <= wvalid_next;
         if (launch) wdata_q <= pending_word;
         if ((state == RESP) && m_axil_bvalid && (m_axil_bresp != 2'b00)) resp_err <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         period_cnt   <= '0;
         window_cnt   <= '0;
         pending      <= 1'b0;
         pending_word <= '0;
         overrun_cnt  <= '0;
      end else begin
         if (!enable || tc) begin
            period_cnt <= '0;
            window_cnt <= '0;
         end else begin
            period_cnt <= period_cnt + 1'b1;
            window_cnt <= window_total;
         end

         // A new snapshot always wins; a launch in the same cycle takes the older word.
         if (tc) begin
            pending      <= 1'b1;
            pending_word <= snap_word;
            if (pending && (state != IDLE) && (overrun_cnt != 8'hFF))
               overrun_cnt <= overrun_cnt + 8'd1;
         end else if (launch) begin
            pending <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_perf_hex_axil_writer.sv
// Bench for perf_hex_axil_writer: a reactive AXI-lite slave, a window-level reference
// model and directed scenarios for latency, backpressure, overrun, error and reset.
module tb_perf_hex_axil_writer;

   localparam int PERIOD_A = 16;

   logic clk, rst;
   int   cyc = 0;
   int   n_cmp = 0, n_err = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // DUT A: short window, reactive slave
   logic        enable_a, instr_a;
   logic [15:0] awaddr_a;
   logic [2:0]  awprot_a;
   logic        awvalid_a, awready_a, wvalid_a, wready_a, bvalid_a, bready_a;
   logic [31:0] wdata_a;
   logic [3:0]  wstrb_a;
   logic [1:0]  bresp_a;
   logic        busy_a, resp_err_a;
   logic [7:0]  overrun_a;

   perf_hex_axil_writer #(.UPDATE_PERIOD(PERIOD_A), .COUNT_SHIFT(0)) dut_a (
      .clk(clk), .rst(rst), .enable(enable_a), .instr_retired(instr_a),
      .m_axil_awaddr(awaddr_a), .m_axil_awprot(awprot_a), .m_axil_awvalid(awvalid_a),
      .m_axil_awready(awready_a), .m_axil_wdata(wdata_a), .m_axil_wstrb(wstrb_a),
      .m_axil_wvalid(wvalid_a), .m_axil_wready(wready_a), .m_axil_bresp(bresp_a),
      .m_axil_bvalid(bvalid_a), .m_axil_bready(bready_a), .busy(busy_a),
      .overrun_cnt(overrun_a), .resp_err(resp_err_a)
   );

   // DUTs B and C: long windows for saturation/packing, always-ready slave
   logic        enable_b, instr_b, enable_c, instr_c;
   logic        sl_ready, sl_bvalid;
   logic [1:0]  sl_bresp;
   logic [15:0] awaddr_b, awaddr_c;
   logic [2:0]  awprot_b, awprot_c;
   logic        awvalid_b, awvalid_c, wvalid_b, wvalid_c, bready_b, bready_c;
   logic [31:0] wdata_b, wdata_c;
   logic [3:0]  wstrb_b, wstrb_c;
   logic        busy_b, busy_c, resp_err_b, resp_err_c;
   logic [7:0]  overrun_b, overrun_c;

   perf_hex_axil_writer #(.UPDATE_PERIOD(5000), .COUNT_SHIFT(0)) dut_b (
      .clk(clk), .rst(rst), .enable(enable_b), .instr_retired(instr_b),
      .m_axil_awaddr(awaddr_b), .m_axil_awprot(awprot_b), .m_axil_awvalid(awvalid_b),
      .m_axil_awready(sl_ready), .m_axil_wdata(wdata_b), .m_axil_wstrb(wstrb_b),
      .m_axil_wvalid(wvalid_b), .m_axil_wready(sl_ready), .m_axil_bresp(sl_bresp),
      .m_axil_bvalid(sl_bvalid), .m_axil_bready(bready_b), .busy(busy_b),
      .overrun_cnt(overrun_b), .resp_err(resp_err_b)
   );

   perf_hex_axil_writer #(.UPDATE_PERIOD(70000), .COUNT_SHIFT(0)) dut_c (
      .clk(clk), .rst(rst), .enable(enable_c), .instr_retired(instr_c),
      .m_axil_awaddr(awaddr_c), .m_axil_awprot(awprot_c), .m_axil_awvalid(awvalid_c),
      .m_axil_awready(sl_ready), .m_axil_wdata(wdata_c), .m_axil_wstrb(wstrb_c),
      .m_axil_wvalid(wvalid_c), .m_axil_wready(sl_ready), .m_axil_bresp(sl_bresp),
      .m_axil_bvalid(sl_bvalid), .m_axil_bready(bready_c), .busy(busy_c),
      .overrun_cnt(overrun_c), .resp_err(resp_err_c)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [31:0] model_word(input longint count, input int shift);
      longint      s;
      logic [15:0] v;
      s = count >>> shift;
      v = (s > 65535) ? 16'hFFFF : 16'(s);
      return {v[15:8], 16'h0000, v[7:0]};
   endfunction

   // Reference model: a window is PERIOD_A consecutive enabled, non-reset cycles;
   // its word is built from the number of pulses seen in it.
   bit          win_q[$];
   logic [31:0] exp_q[$];
   initial forever begin
      @(negedge clk);
      if (rst || !enable_a) begin
         win_q.delete();
      end else begin
         win_q.push_back(instr_a);
         if (win_q.size() == PERIOD_A) begin
            int pulses;
            pulses = 0;
            foreach (win_q[i]) pulses += int'(win_q[i]);
            exp_q.push_back(model_word(pulses, 0));
            win_q.delete();
         end
      end
   end

   // Reactive slave for DUT A with configurable or random per-transaction delays
   bit          in_txn, aw_done, w_done, b_started;
   bit          aw_hs_prev, w_hs_prev, b_hs_prev;
   bit          err_once, cfg_rand;
   int          cfg_aw, cfg_w, cfg_b, aw_dly, w_dly, b_dly, aw_cnt, w_cnt, b_cnt, b_count;
   int          t_aw_rise, t_aw_hs, t_w_hs, t_b_start;
   logic [31:0] wd_first;
   logic [31:0] obs_q[$];

   initial begin
      awready_a = 1'b0; wready_a = 1'b0; bvalid_a = 1'b0; bresp_a = 2'b00;
      forever begin
         @(posedge clk);
         #2;
         awready_a = 1'b0; wready_a = 1'b0; bvalid_a = 1'b0; bresp_a = 2'b00;
         if (rst) begin
            in_txn = 0; aw_done = 0; w_done = 0; b_started = 0;
            aw_hs_prev = 0; w_hs_prev = 0; b_hs_prev = 0;
         end else begin
            if (aw_hs_prev) begin check("awvalid_drop", awvalid_a, 0); aw_done = 1; end
            if (w_hs_prev)  begin check("wvalid_drop", wvalid_a, 0);   w_done  = 1; end
            if (b_hs_prev) begin
               check("bready_drop", bready_a, 0);
               in_txn = 0; aw_done = 0; w_done = 0; b_started = 0;
            end
            aw_hs_prev = 0; w_hs_prev = 0; b_hs_prev = 0;

            if (!in_txn && awvalid_a) begin
               in_txn = 1; t_aw_rise = cyc; wd_first = wdata_a;
               aw_cnt = 0; w_cnt = 0; b_cnt = 0;
               check("wvalid_with_awvalid", wvalid_a, 1);
               if (cfg_rand) begin
                  aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3); b_dly = $urandom_range(0, 3);
               end else begin
                  aw_dly = cfg_aw; w_dly = cfg_w; b_dly = cfg_b;
               end
            end

            if (in_txn && !aw_done) begin
               if (aw_cnt >= aw_dly) begin
                  awready_a = 1'b1; aw_hs_prev = 1; t_aw_hs = cyc;
                  check("awvalid_at_hs", awvalid_a, 1);
                  check("awaddr", awaddr_a, 0);
                  check("awprot", awprot_a, 0);
               end
               aw_cnt++;
            end

            if (in_txn && !w_done) begin
               if (w_cnt >= w_dly) begin
                  wready_a = 1'b1; w_hs_prev = 1; t_w_hs = cyc;
                  check("wvalid_at_hs", wvalid_a, 1);
                  check("wdata_stable", wdata_a, wd_first);
                  check("wstrb", wstrb_a, 4'hF);
                  obs_q.push_back(wdata_a);
               end
               w_cnt++;
            end

            if (in_txn && aw_done && w_done) begin
               if (!b_started) begin
                  b_started = 1; t_b_start = cyc;
                  check("bready_rise", bready_a, 1);
               end
               if (b_cnt >= b_dly) begin
                  bvalid_a = 1'b1;
                  bresp_a  = err_once ? 2'b10 : 2'b00;
                  err_once = 0; b_hs_prev = 1; b_count++;
                  check("bready_at_hs", bready_a, 1);
               end
               b_cnt++;
            end
         end
      end
   end

   logic [31:0] obs_b[$], obs_c[$];
   initial forever begin
      @(negedge clk);
      if (wvalid_b && sl_ready) obs_b.push_back(wdata_b);
      if (wvalid_c && sl_ready) obs_c.push_back(wdata_c);
   end

   logic [31:0] want_q[$];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic reset_queues();
      obs_q.delete();
      exp_q.delete();
      b_count = 0;
   endtask

   // Idle means three quiet cycles in a row, so a pending launch cannot slip past.
   task automatic wait_idle(input int budget);
      bit timed_out;
      int quiet;
      timed_out = 1; quiet = 0;
      for (int k = 0; k < budget; k++) begin
         @(posedge clk);
         #3;
         quiet = (!busy_a && !in_txn) ? quiet + 1 : 0;
         if (quiet >= 3) begin
            timed_out = 0;
            break;
         end
      end
      check("idle_timeout", timed_out, 0);
   endtask

   task automatic compare_writes(input string tag);
      check({tag, "_count"}, obs_q.size(), want_q.size());
      for (int i = 0; i < obs_q.size() && i < want_q.size(); i++)
         check({tag, "_wdata"}, obs_q[i], want_q[i]);
   endtask

   int c0, r0;
   bit launch_to;

   initial begin
      rst = 1'b1;
      enable_a = 0; instr_a = 0; enable_b = 0; instr_b = 0; enable_c = 0; instr_c = 0;
      sl_ready = 1'b1; sl_bvalid = 1'b1; sl_bresp = 2'b00;
      cfg_rand = 0; cfg_aw = 0; cfg_w = 0; cfg_b = 0; err_once = 0; b_count = 0;

      repeat (3) tick();
      @(negedge clk);
      check("rst_awvalid", awvalid_a, 0);
      check("rst_wvalid", wvalid_a, 0);
      check("rst_bready", bready_a, 0);
      check("rst_busy", busy_a, 0);
      check("rst_overrun", overrun_a, 0);
      check("rst_resp_err", resp_err_a, 0);
      check("rst_wdata", wdata_a, 0);
      tick();
      rst = 1'b0;

      // T1: full-rate window, zero-wait slave, minimum latency
      reset_queues();
      tick();
      c0 = cyc;
      for (int k = 0; k < 20; k++) begin enable_a = 1; instr_a = 1; tick(); end
      enable_a = 0; instr_a = 0;
      wait_idle(60);
      want_q = exp_q;
      compare_writes("t1");
      if (obs_q.size() > 0) check("t1_wdata_0x10", obs_q[0], 32'h0000_0010);
      check("t1_aw_latency", t_aw_rise - c0, 17);
      check("t1_b_latency", t_b_start - c0, 18);
      check("t1_bcount", b_count, 1);

      // T2: random pulses, enable dropouts, random slave delays
      reset_queues();
      cfg_rand = 1;
      for (int k = 0; k < 640; k++) begin
         enable_a = ($urandom_range(0, 49) != 0);
         instr_a  = $urandom_range(0, 1);
         tick();
      end
      enable_a = 0; instr_a = 0;
      wait_idle(80);
      want_q = exp_q;
      compare_writes("t2");
      check("t2_bcount", b_count, exp_q.size());
      check("t2_overrun", overrun_a, 0);
      cfg_rand = 0;

      // T3: staggered AW/W readiness
      reset_queues();
      cfg_aw = 1; cfg_w = 3; cfg_b = 0;
      for (int k = 0; k < 16; k++) begin enable_a = 1; instr_a = 1; tick(); end
      enable_a = 0; instr_a = 0;
      wait_idle(60);
      want_q = exp_q;
      compare_writes("t3");
      check("t3_aw_hs", t_aw_hs - t_aw_rise, 1);
      check("t3_w_hs", t_w_hs - t_aw_rise, 3);
      check("t3_bready_next", t_b_start - t_w_hs, 1);
      check("t3_bcount", b_count, 1);

      // T4: slow response -> middle window dropped, latest wins
      reset_queues();
      cfg_aw = 0; cfg_w = 0; cfg_b = 40;
      for (int k = 0; k < 50; k++) begin
         enable_a = 1;
         instr_a  = (k < 16) ? 1'b1 : (k < 32) ? (k % 3 == 0) : (k % 2 == 0);
         tick();
      end
      enable_a = 0; instr_a = 0;
      wait_idle(200);
      want_q.delete();
      if (exp_q.size() >= 3) want_q = '{exp_q[0], exp_q[2]};
      else want_q = exp_q;
      compare_writes("t4");
      check("t4_overrun", overrun_a, 1);
      check("t4_bcount", b_count, 2);

      // T5: error response is sticky across later OKAY writes
      reset_queues();
      cfg_b = 0; err_once = 1;
      check("t5_err_before", resp_err_a, 0);
      for (int k = 0; k < 16; k++) begin enable_a = 1; instr_a = $urandom_range(0, 1); tick(); end
      enable_a = 0; instr_a = 0;
      wait_idle(60);
      check("t5_err_set", resp_err_a, 1);
      for (int k = 0; k < 32; k++) begin enable_a = 1; instr_a = $urandom_range(0, 1); tick(); end
      enable_a = 0; instr_a = 0;
      wait_idle(60);
      check("t5_err_sticky", resp_err_a, 1);
      check("t5_overrun_kept", overrun_a, 1);
      check("t5_bcount", b_count, 3);
      want_q = exp_q;
      compare_writes("t5");

      // T6: reset while stalled in the address/data phase
      reset_queues();
      cfg_aw = 10; cfg_w = 10;
      launch_to = 1;
      for (int k = 0; k < 40; k++) begin
         enable_a = 1; instr_a = 1;
         tick();
         if (in_txn) begin launch_to = 0; break; end
      end
      check("t6_launch_timeout", launch_to, 0);
      tick();
      tick();
      rst = 1'b1;
      r0 = cyc;
      cfg_aw = 0; cfg_w = 0;
      tick();
      rst = 1'b0;
      @(negedge clk);
      check("t6_awvalid", awvalid_a, 0);
      check("t6_wvalid", wvalid_a, 0);
      check("t6_bready", bready_a, 0);
      check("t6_busy", busy_a, 0);
      check("t6_overrun", overrun_a, 0);
      check("t6_resp_err", resp_err_a, 0);
      check("t6_wdata", wdata_a, 0);
      reset_queues();
      repeat (16) tick();
      enable_a = 0; instr_a = 0;
      wait_idle(60);
      want_q = exp_q;
      compare_writes("t6");
      check("t6_aw_after_window", t_aw_rise - r0, 18);

      // T7: byte packing and 16-bit saturation on long windows
      fork
         begin
            for (int k = 0; k < 5000; k++) begin
               enable_b = 1; instr_b = (k < 4660);
               @(posedge clk);
               #1;
            end
            enable_b = 0; instr_b = 0;
         end
         begin
            for (int k = 0; k < 70000; k++) begin
               enable_c = 1; instr_c = 1;
               @(posedge clk);
               #1;
            end
            enable_c = 0; instr_c = 0;
         end
      join
      repeat (10) tick();
      check("b_count", obs_b.size(), 1);
      if (obs_b.size() > 0) check("b_wdata", obs_b[0], model_word(4660, 0));
      check("c_count", obs_c.size(), 1);
      if (obs_c.size() > 0) check("c_wdata", obs_c[0], model_word(70000, 0));
      check("c_overrun", overrun_c, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
